core_line_buffer_flatten_n: RTL and testbench

Parametrised flatten stage for the CNN back end.
- Pops one word from each of NCH parallel per-channel feature-map FIFOs as a single group, then serialises the group onto one output FIFO, channel 0 first.
- The resulting stream is in HWC order (pixel-major, channel-minor), which is the order the dense layer consumes.
- Sits between the last conv/pool stage's per-channel FIFOs and the fully-connected input FIFO.
- Supports any channel count, applies full backpressure, and detects end of frame.

---
 rtl/core_line_buffer_flatten_n_pkg.sv | 24 ++
 rtl/core_line_buffer_flatten_n_if.sv | 34 +++
 rtl/core_line_buffer_flatten_n_hold_mux.sv | 34 +++
 rtl/core_line_buffer_flatten_n.sv | 130 +++++++++++++
 tb/tb_core_line_buffer_flatten_n.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_line_buffer_flatten_n_pkg.sv
// flatten_pkg: shared types and constants for the flatten stage.
//   state_t    - FSM encoding (IDLE, POP, CAP, EMIT)
//   idx_width  - width of a channel / counter index, never below 1 bit
//   DEF_*      - default geometry used by the interface and the top
package flatten_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_NCH    = 16;
  localparam int DEF_WIDTH  = 28;
  localparam int DEF_HEIGHT = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAP  = 2'd2,
    EMIT = 2'd3
  } state_t;

  // Bits needed to index n items; a single item still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_line_buffer_flatten_n_if.sv
// core_line_buffer_flatten_n_if: FIFO-side signals of the flatten stage.
//   ff_rdata / ff_empty / ff_rdreq : NCH parallel non-show-ahead input FIFOs
//                                    (channel k at ff_rdata[k*DWIDTH +: DWIDTH])
//   ff_wdata / ff_wrreq / ff_full  : single output FIFO
// Handshake: a group is popped only when every ff_empty bit is low and ff_full
// is low; ff_rdreq is a one-cycle pop strobe whose data appears on ff_rdata the
// following cycle. A word is transferred on every cycle ff_wrreq is high, and
// ff_wrreq is never high while ff_full is high.
// Modports: slave = the flatten stage, master = the FIFO environment.
interface core_line_buffer_flatten_n_if
  import flatten_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int NCH    = DEF_NCH
);

  logic [NCH*DWIDTH-1:0] ff_rdata;
  logic [NCH-1:0]        ff_empty;
  logic                  ff_rdreq;
  logic [DWIDTH-1:0]     ff_wdata;
  logic                  ff_wrreq;
  logic                  ff_full;

  modport slave (
    input  ff_rdata, ff_empty, ff_full,
    output ff_rdreq, ff_wdata, ff_wrreq
  );

  modport master (
    output ff_rdata, ff_empty, ff_full,
    input  ff_rdreq, ff_wdata, ff_wrreq
  );

endinterface

// File: rtl/core_line_buffer_flatten_n_hold_mux.sv
// flatten_hold_mux: NCH-word capture register plus the idx-selected read mux.
//   clock, reset_n : clock, asynchronous active-low reset (clears all words)
//   capture        : load all NCH words from rdata this cycle
//   rdata          : packed input words, word k at [k*DWIDTH +: DWIDTH]
//   idx            : word select
//   dout           : hold[idx], stable whenever capture is low
module flatten_hold_mux
  import flatten_pkg::*;
#(
  parameter  int DWIDTH = DEF_DWIDTH,
  parameter  int NCH    = DEF_NCH,
  localparam int CW     = idx_width(NCH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  capture,
  input  logic [NCH*DWIDTH-1:0] rdata,
  input  logic [CW-1:0]         idx,
  output logic [DWIDTH-1:0]     dout
);

  logic [DWIDTH-1:0] hold [NCH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) hold[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NCH; k++) hold[k] <= rdata[k*DWIDTH +: DWIDTH];
    end
  end

  assign dout = hold[idx];

endmodule

// File: rtl/core_line_buffer_flatten_n.sv
// core_line_buffer_flatten_n: pops one word from each of NCH channel FIFOs as a
// group and serialises the group onto one output FIFO, channel 0 first, giving
// an HWC-ordered stream for the dense layer.
//   clock, reset_n : clock, asynchronous active-low reset
//   ff (slave)     : input FIFO bank and output FIFO signals
//   state_dbg      : current FSM state
//   busy           : high in any state other than IDLE
//   frame_done     : (FLATTEN_FRAME_CNT_EN only) one-cycle pulse on the last
//                    write of pixel group WIDTH*HEIGHT-1
// Optional feature macro: FLATTEN_FRAME_CNT_EN.
// Timing: POP, CAP, then NCH EMIT cycles per group; a finished group goes
// straight to POP when the next group is ready.
module core_line_buffer_flatten_n
  import flatten_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int NCH    = DEF_NCH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                        clock,
  input  logic                        reset_n,
  core_line_buffer_flatten_n_if.slave ff,
  output state_t                      state_dbg,
  output logic                        busy
`ifdef FLATTEN_FRAME_CNT_EN
  ,
  output logic                        frame_done
`endif
);

  localparam int            CW       = idx_width(NCH);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          rdreq_q;
  logic          ready;
  logic          last;
  logic          wr;
  logic          capture;

  assign ready = (ff.ff_empty == '0) & ~ff.ff_full;
  assign last  = (idx_q == LAST_IDX);
  // Write strobe is combinational from ff_full so a full FIFO stalls EMIT in
  // the same cycle; idx and hold stay put, so the stalled word is re-presented.
  assign wr    = (state_q == EMIT) & ~ff.ff_full;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (ready) state_d = POP;
      POP:  state_d = CAP;
      CAP: begin
        // q of a non-show-ahead FIFO is valid the cycle after rdreq.
        capture = 1'b1;
        idx_d   = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (wr) begin
          if (last) begin
            idx_d   = '0;
            state_d = ready ? POP : IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdreq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdreq_q <= (state_d == POP);
    end
  end

  flatten_hold_mux #(
    .DWIDTH (DWIDTH),
    .NCH    (NCH)
  ) u_hold_mux (
    .clock   (clock),
    .reset_n (reset_n),
    .capture (capture),
    .rdata   (ff.ff_rdata),
    .idx     (idx_q),
    .dout    (ff.ff_wdata)
  );

  assign ff.ff_rdreq = rdreq_q;
  assign ff.ff_wrreq = wr;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

`ifdef FLATTEN_FRAME_CNT_EN
  localparam int            FRAME_GRPS = WIDTH * HEIGHT;
  localparam int            FW         = idx_width(FRAME_GRPS);
  localparam logic [FW-1:0] LAST_GRP   = FW'(FRAME_GRPS - 1);

  logic [FW-1:0] grp_q;
  logic          grp_done;

  assign grp_done   = wr & last;
  assign frame_done = grp_done & (grp_q == LAST_GRP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grp_q <= '0;
    end else if (grp_done) begin
      grp_q <= frame_done ? '0 : grp_q + FW'(1);
    end
  end
`else
  // Frame geometry only matters to the frame counter; this empty block keeps
  // WIDTH and HEIGHT referenced when the counter is not built.
  if (WIDTH < 1 || HEIGHT < 1) begin : g_frame_geometry_unused
  end
`endif

endmodule

// File: tb/tb_core_line_buffer_flatten_n.sv
// tb_core_line_buffer_flatten_n: directed and randomized bench for the flatten
// stage. Input FIFOs are modelled as per-channel queues (non-show-ahead: data
// updates just after the popping edge); expected output is the channel-order
// concatenation of each scheduled group, checked word by word.
module tb_core_line_buffer_flatten_n;
  import flatten_pkg::*;

  localparam int DWIDTH = 32;
`ifdef FLATTEN_FRAME_CNT_EN
  localparam int NCH    = 3;
  localparam int WIDTH  = 2;
  localparam int HEIGHT = 2;
  localparam int FRAME_WORDS = WIDTH * HEIGHT * NCH;
`else
  localparam int NCH    = 16;
  localparam int WIDTH  = 28;
  localparam int HEIGHT = 28;
`endif
  localparam int HB       = (NCH > 3) ? 3 : NCH - 1;  // held-back channel
  localparam int STALL_AT = (NCH > 8) ? 7 : NCH - 1;
  localparam int RS_AT    = (NCH > 6) ? 5 : NCH - 1;

  // ---------------- clock / reset ----------------
  logic   clock;
  logic   reset_n;
  state_t state_dbg;
  logic   busy;
`ifdef FLATTEN_FRAME_CNT_EN
  logic   frame_done;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  core_line_buffer_flatten_n_if #(.DWIDTH(DWIDTH), .NCH(NCH)) ifc ();

  core_line_buffer_flatten_n #(
    .DWIDTH (DWIDTH),
    .NCH    (NCH),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ff         (ifc.slave),
    .state_dbg  (state_dbg),
    .busy       (busy)
`ifdef FLATTEN_FRAME_CNT_EN
    ,
    .frame_done (frame_done)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [DWIDTH-1:0] exp_q[$];
  logic [DWIDTH-1:0] ch_q [NCH][$];
  int n_chk, n_fail;
  int cyc, pops, n_wr, wr_in_grp, busy_cyc, frame_wr;
  int last_pop_cyc, first_pop_cyc, first_wr_cyc, last_wr_cyc;
  bit pop_pend, span_arm, rand_full_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- FIFO environment ----------------
  task automatic update_empty();
    for (int k = 0; k < NCH; k++) ifc.ff_empty[k] = (ch_q[k].size() == 0);
  endtask

  task automatic push_word(input int k, input logic [DWIDTH-1:0] v);
    ch_q[k].push_back(v);
    update_empty();
  endtask

  task automatic push_group_base(input logic [DWIDTH-1:0] base);
    for (int k = 0; k < NCH; k++) begin
      exp_q.push_back(base + DWIDTH'(k));
      push_word(k, base + DWIDTH'(k));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || ifc.ff_empty != '1) && n < bound) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  always @(posedge clock) cyc++;

  // Pop lands on the edge after rdreq was sampled; q changes just after it.
  always @(posedge clock) begin
    #1;
    if (pop_pend) begin
      pop_pend = 1'b0;
      for (int k = 0; k < NCH; k++)
        if (ch_q[k].size() != 0) ifc.ff_rdata[k*DWIDTH +: DWIDTH] = ch_q[k].pop_front();
      update_empty();
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_full_en) ifc.ff_full = ($urandom_range(0, 2) == 0);
  end

  // ---------------- monitor (mid-cycle sampling) ----------------
  always @(negedge clock) begin
    logic [DWIDTH-1:0] exp_w;
    if (ifc.ff_rdreq) begin
      check("rdreq_when_empty", ifc.ff_empty, '0);
      pop_pend = 1'b1;
      pops++;
      last_pop_cyc = cyc;
      if (span_arm) begin
        first_pop_cyc = cyc;
        span_arm = 1'b0;
      end
    end
    if (ifc.ff_wrreq) begin
      check("wrreq_when_full", ifc.ff_full, 0);
      if (exp_q.size() == 0) check("spurious_write", ifc.ff_wrreq, 1'b0);
      else begin
        exp_w = exp_q.pop_front();
        check("wdata", ifc.ff_wdata, exp_w);
      end
      if (wr_in_grp == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      n_wr++;
      wr_in_grp = (wr_in_grp == NCH - 1) ? 0 : wr_in_grp + 1;
`ifdef FLATTEN_FRAME_CNT_EN
      check("frame_done", frame_done, ((frame_wr % FRAME_WORDS) == FRAME_WORDS - 1));
      frame_wr++;
    end else if (frame_done) begin
      check("frame_done_no_write", frame_done, 1'b0);
`endif
    end
    if (busy) busy_cyc++;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DWIDTH-1:0] w [NCH];
    int hold_ch, n, wr0;
    reset_n = 1'b0;
    ifc.ff_full = 1'b0;
    ifc.ff_rdata = '0;
    update_empty();
    repeat (3) tick();
    reset_n = 1'b1;

    // 1: idle with all FIFOs empty
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_rdreq", ifc.ff_rdreq, 1'b0);
      check("idle_wrreq", ifc.ff_wrreq, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    check("idle_state", state_dbg, IDLE);

    // 2: single group, latency 2 cycles from POP to first write
    pops = 0;
    wr0 = n_wr;
    push_group_base(32'h100);
    wait_drain("single_drain", 200);
    check("single_pops", pops, 1);
    check("single_writes", n_wr - wr0, NCH);
    check("single_latency", first_wr_cyc - last_pop_cyc, 2);

    // 3: backpressure mid-group
    wr0 = n_wr;
    push_group_base(32'h100);
    n = 0;
    while (wr_in_grp != STALL_AT && n < 200) begin
      tick();
      n++;
    end
    check("stall_reached", wr_in_grp, STALL_AT);
    ifc.ff_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_wrreq", ifc.ff_wrreq, 1'b0);
      check("stall_wdata", ifc.ff_wdata, 32'h100 + STALL_AT);
      tick();
    end
    ifc.ff_full = 1'b0;
    wait_drain("stall_drain", 200);
    check("stall_writes", n_wr - wr0, NCH);

    // 4: one channel empty blocks the pop; then 3 back-to-back groups
    for (int k = 0; k < NCH; k++) begin
      exp_q.push_back(32'h300 + k);
      if (k != HB) push_word(k, 32'h300 + k);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("partial_rdreq", ifc.ff_rdreq, 1'b0);
      check("partial_busy", busy, 1'b0);
    end
    push_word(HB, 32'h300 + HB);
    wait_drain("partial_drain", 200);

    busy_cyc = 0;
    pops = 0;
    span_arm = 1'b1;
    for (int g = 0; g < 3; g++) push_group_base(32'h1000 * (g + 1));
    wait_drain("stream_drain", 400);
    check("stream_pops", pops, 3);
    check("stream_busy_cycles", busy_cyc, 3 * (NCH + 2));
    check("stream_span", last_wr_cyc - first_pop_cyc + 1, 3 * (NCH + 2));

    // 5: asynchronous reset in the middle of EMIT
    push_group_base(32'h500);
    n = 0;
    while (wr_in_grp != RS_AT && n < 200) begin
      tick();
      n++;
    end
    check("rst_reached", wr_in_grp, RS_AT);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_wrreq", ifc.ff_wrreq, 1'b0);
    check("rst_rdreq", ifc.ff_rdreq, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wdata", ifc.ff_wdata, '0);
    check("rst_state", state_dbg, IDLE);
    exp_q.delete();
    wr_in_grp = 0;
    frame_wr = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    wr0 = n_wr;
    push_group_base(32'h200);
    wait_drain("post_rst_drain", 200);
    check("post_rst_writes", n_wr - wr0, NCH);

    // 6: randomized groups, staggered channel arrival, random backpressure
    rand_full_en = 1'b1;
    for (int g = 0; g < 40; g++) begin
      for (int k = 0; k < NCH; k++) begin
        w[k] = $urandom;
        exp_q.push_back(w[k]);
      end
      hold_ch = $urandom_range(0, NCH - 1);
      for (int k = 0; k < NCH; k++) if (k != hold_ch) push_word(k, w[k]);
      repeat ($urandom_range(0, 3)) tick();
      push_word(hold_ch, w[hold_ch]);
      repeat ($urandom_range(0, NCH + 4)) tick();
    end
    rand_full_en = 1'b0;
    tick();
    ifc.ff_full = 1'b0;
    wait_drain("random_drain", 4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation passed %0d cycles without finishing", cyc);
    $fatal(1);
  end

endmodule
